// File: rtl/sprite_draw.sv
// Sprite overlay stage: latches sprite position once per frame, addresses the
// sprite ROM and merges the returned colour with the background, 3 clk latency.
module sprite_draw #(
    parameter int          WIDTH       = 50,
    parameter int          HEIGHT      = 100,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mirror,
    output logic [19:0] rom_address,
    input  logic [11:0] rom_data,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam logic [12:0] W13 = 13'(WIDTH);
    localparam logic [12:0] H13 = 13'(HEIGHT);
    localparam logic [19:0] W20 = 20'(WIDTH);

    logic [11:0] x_l;
    logic [11:0] y_l;
    logic        mirror_l;

    vga_t        s0;
    vga_t        s1;
    vga_t        s2;
    logic        f1;
    logic        f2;

    logic [12:0] hc;
    logic [12:0] vc;
    logic [12:0] xs;
    logic [12:0] ys;
    logic [12:0] dx;
    logic [12:0] dy;
    logic [12:0] col;
    logic        in_sprite;
    logic [19:0] addr;
    logic        frame_start;

    assign s0 = '{hcount: hcount_in, vcount: vcount_in,
                  hsync: hsync_in, vsync: vsync_in,
                  hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    // 13-bit arithmetic so that position + size can never wrap around.
    always_comb begin
        hc        = {2'b00, hcount_in};
        vc        = {2'b00, vcount_in};
        xs        = {1'b0, x_l};
        ys        = {1'b0, y_l};
        dx        = hc - xs;
        dy        = vc - ys;
        in_sprite = (hc >= xs) && (hc < xs + W13) &&
                    (vc >= ys) && (vc < ys + H13);
        col       = mirror_l ? (W13 - 13'd1 - dx) : dx;
        addr      = 20'(dy) * W20 + 20'(col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_l      <= '0;
            y_l      <= '0;
            mirror_l <= 1'b0;
        end else if (frame_start) begin
            x_l      <= xpos;
            y_l      <= ypos;
            mirror_l <= mirror;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_address <= '0;
            s1          <= '0;
            s2          <= '0;
            f1          <= 1'b0;
            f2          <= 1'b0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= '0;
        end else begin
            rom_address <= in_sprite ? addr : 20'd0;
            s1          <= s0;
            f1          <= in_sprite;
            s2          <= s1;
            f2          <= f1;
            hcount_out  <= s2.hcount;
            vcount_out  <= s2.vcount;
            hsync_out   <= s2.hsync;
            vsync_out   <= s2.vsync;
            hblnk_out   <= s2.hblnk;
            vblnk_out   <= s2.vblnk;
            if (s2.hblnk || s2.vblnk)
                rgb_out <= 12'h000;
            else if (f2 && (rom_data != TRANSPARENT))
                rgb_out <= rom_data;
            else
                rgb_out <= s2.rgb;
        end
    end

endmodule

// File: doc/sprite_draw.md
# sprite_draw

Pixel-pipeline stage that overlays a ROM-stored sprite (e.g. the Tom or Jerry model) onto the VGA background stream. It acts as the initiator on the sprite-ROM read port: it issues a 20-bit pixel address per cycle, absorbs the ROM's one-cycle read latency, and merges the returned 12-bit colour with the delayed background pixel. It sits between the background draw stage and the VGA output register, one instance per sprite.

## Interface
- WIDTH, 50: sprite width in pixels.
- HEIGHT, 100: sprite height in pixels; WIDTH*HEIGHT must not exceed ROM depth.
- TRANSPARENT, 12'hF0F: ROM colour treated as see-through.
- clk  in  1  pixel clock; everything sequential on posedge.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical line counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing from the previous stage.
- rgb_in  in  12  background pixel.
- xpos  in  12  sprite left edge (screen x), unsigned.
- ypos  in  12  sprite top edge (screen y), unsigned.
- mirror  in  1  1 = draw horizontally flipped.
- rom_address  out  20  read address to sprite ROM.
- rom_data  in  12  ROM output, valid one clk after rom_address.
- hcount_out, vcount_out  out  11  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited pixel.

## Operation
- Frame latch: xpos, ypos, mirror are captured into internal registers only on the cycle where hcount_in == 0 and vcount_in == 0. Changes at any other time take effect from the next frame; the sprite never tears mid-frame.
- Stage 1 (hit/address): in_sprite = (hcount_in >= x_l) && (hcount_in < x_l + WIDTH) && (vcount_in >= y_l) && (vcount_in < y_l + HEIGHT). Comparisons in 13-bit unsigned arithmetic so x_l + WIDTH never wraps. col = hcount_in - x_l, or WIDTH-1-(hcount_in - x_l) when mirror_l = 1; row = vcount_in - y_l. rom_address <= in_sprite ? row*WIDTH + col : 20'd0, zero-extended to 20 bits. Registered in_sprite flag travels with the pipeline.
- Stage 2 (ROM wait): flag, timing and rgb_in delayed one more cycle; rom_data becomes valid here.
- Stage 3 (merge): rgb_out <= (hblnk|vblnk delayed) ? 12'h000 : (flag && rom_data != TRANSPARENT) ? rom_data : rgb delayed.
- Sprite partly off-screen (x_l + WIDTH > 1023 or beyond visible area): only pixels whose counters occur are drawn; no wrap to the left edge or next line.
- xpos/ypos far beyond counter range: in_sprite never asserts, stream passes through unchanged.
- No handshake with the ROM; one read per clk, every clk.

## Timing
- Latency input -> output: exactly 3 clk for all outputs (counters, syncs, blanks, rgb); all delayed signals stay mutually aligned.
- rom_address registered: valid 1 clk after the corresponding hcount_in.
- Reset (rst high at posedge): all pipeline registers, rom_address, all outputs and x_l/y_l/mirror_l go to 0 on that edge; outputs stay 0 while rst is held. After release, first valid output appears 3 clk after the first sampled input; the latched position stays 0 until the next hcount=vcount=0 cycle.
- Reset mid-frame: pipeline flushed, no stale sprite pixels emitted after release.

## Test plan
- Pass-through: xpos=ypos=2000, rgb_in=12'h123 constant -> rgb_out=12'h123 in visible area, 0 in blanking, 3 clk latency; rom_address stays 0.
- Top-left pixel: xpos=100, ypos=50, hcount=100, vcount=50, rom model returns address as data -> rom_address=0 one clk later, rgb_out=rom[0] 3 clk after input.
- Last pixel and edge: hcount=149, vcount=149 -> rom_address=4999; hcount=150 -> background pixel, no address 5000 issued.
- Mirror: mirror=1, xpos=100, ypos=50, hcount=100, vcount=51 -> rom_address=99 (row 1, col 49).
- Transparency: rom_data=12'hF0F inside sprite, rgb_in=12'hABC -> rgb_out=12'hABC; rom_data=12'h0F0 -> rgb_out=12'h0F0.
- Frame latch and reset: change xpos 100->300 at vcount=200 -> sprite columns unchanged until next frame; assert rst mid-line -> all outputs 0 next edge, sprite reappears only after next hcount=vcount=0.
